// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared constants for the instruction prefetch queue.
//   ADDR_W_DEF / DATA_W_DEF : default address / instruction widths
//   state_e                 : fetch FSM encoding
//   OP_END                  : END opcode; the controller raises halt when it sees it
package instr_fetch_queue_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam logic [7:0] OP_END = 8'hF0;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_FULL   = 2'd1,
    S_HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: RAM read port, consumer handshake and control pulses
// of the prefetch queue.
//   master : the fetch queue (drives mem_addr/mem_en and the instr* head outputs)
//   slave  : RAM + consumer side (drives mem_data, instr_ready, redirect, halt)
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic [CW-1:0]     count;

  modport master (
    output mem_addr, mem_en, instr, instr_pc, instr_valid, count,
    input  mem_data, instr_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_addr, mem_en, instr, instr_pc, instr_valid, count,
    output mem_data, instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// instr_fetch_queue_sync_fifo: DEPTH-entry FIFO with a registered show-ahead head.
//   clk, reset (sync, active-low)
//   flush          : drop all entries, pointers back to 0 (head register holds)
//   push/push_data : write an entry (caller never pushes when full)
//   pop            : retire the head (caller only pops when count != 0)
//   head           : registered head entry, holds its last value when empty
//   count          : occupied entries
module instr_fetch_queue_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]    cnt_after_pop, cnt_nxt;
  logic             bypass;

  assign rd_nxt        = rd_ptr + PW'(pop);
  assign cnt_after_pop = count - CW'(pop);
  assign cnt_nxt       = cnt_after_pop + CW'(push);
  // If nothing is left behind the pop, the new head is the word being written now.
  assign bypass        = push && (cnt_after_pop == '0);

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (cnt_nxt != '0) head <= bypass ? push_data : mem[rd_nxt];
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetch stage between a 1-cycle-latency instruction RAM
// and the controller. Streams sequential words into a FIFO, each tagged with
// its fetch address, and presents them on a valid/ready handshake.
//   clk, reset (sync, active-low)
//   bus.mem_addr/mem_en -> RAM read strobe; bus.mem_data returns next cycle
//   bus.instr/instr_pc/instr_valid, bus.instr_ready : head handshake
//   bus.redirect/redirect_pc : flush everything and restart at redirect_pc
//   bus.halt  : stop issuing (buffered and in-flight words still deliver)
//   bus.count : occupied FIFO entries
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state, state_n;
  logic [ADDR_W-1:0]   fetch_pc, mem_addr_q, rd_tag;
  logic                mem_en_q, rd_pend, issue, issue_ok, push, pop;
  logic [CW-1:0]       cnt, cnt_after;
  logic [CW:0]         occ;
  logic [DATA_W+ADDR_W-1:0] head;

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.count       = cnt;
  assign bus.instr_valid = (cnt != '0);
  assign {bus.instr, bus.instr_pc} = head;

  // Redirect kills both the word on mem_data and any pop in the same cycle.
  assign pop  = bus.instr_valid && bus.instr_ready && !bus.redirect;
  assign push = rd_pend && !bus.redirect;

  // Space check counts entries after this edge plus the read still strobed
  // on the RAM, so the FIFO can never be overrun by returning data.
  assign cnt_after = cnt + CW'(push) - CW'(pop);
  assign occ       = {1'b0, cnt_after} + (CW+1)'(mem_en_q);
  assign issue_ok  = occ < (CW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    if (bus.redirect)  state_n = S_FETCH;
    else if (bus.halt) state_n = S_HALTED;
    else begin
      case (state)
        S_FETCH:  if (issue_ok) issue = 1'b1; else state_n = S_FULL;
        S_FULL:   if (pop) state_n = S_FETCH;
        S_HALTED: state_n = S_HALTED;
        default:  state_n = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc   <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= '0;
    end else begin
      rd_tag <= mem_addr_q;
      if (bus.redirect) begin
        // Target is strobed straight away; the read already on the RAM is dropped.
        mem_en_q   <= 1'b1;
        mem_addr_q <= bus.redirect_pc;
        fetch_pc   <= bus.redirect_pc + ADDR_W'(1);
        rd_pend    <= 1'b0;
      end else begin
        mem_en_q <= issue;
        rd_pend  <= mem_en_q;
        if (issue) begin
          mem_addr_q <= fetch_pc;
          fetch_pc   <= fetch_pc + ADDR_W'(1);
        end
      end
    end
  end

  instr_fetch_queue_sync_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_data ({bus.mem_data, rd_tag}),
    .pop       (pop),
    .head      (head),
    .count     (cnt)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed table of per-edge vectors for reset, streaming
// and fill/drain, plus hand-written sequences for redirect, halt, address wrap
// and mid-stream reset. RAM content is 0x1000_0000 + address.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue_if #(.ADDR_W(16), .DATA_W(32), .DEPTH(4)) bus();

  instr_fetch_queue #(.ADDR_W(16), .DATA_W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_data <= 32'h1000_0000 + 32'(bus.mem_addr);
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] exp_pc;
    logic [2:0]  exp_cnt;
    logic        exp_v;
    logic        exp_en;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0; bus.instr_ready = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int delivered;
    int found;
    reset = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    bus.redirect_pc = '0; bus.halt = 1'b0; bus.mem_data = '0;

    // {rst, rdy, pc, cnt, valid, mem_en, mem_addr} sampled after each edge
    vt.push_back('{1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0});
    vt.push_back('{1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0});
    // streaming with ready high: valid from the third edge, one word per cycle
    vt.push_back('{1'b1, 1'b1, 16'h0, 3'd0, 1'b0, 1'b1, 16'h0});
    vt.push_back('{1'b1, 1'b1, 16'h0, 3'd0, 1'b0, 1'b1, 16'h1});
    vt.push_back('{1'b1, 1'b1, 16'h0, 3'd1, 1'b1, 1'b1, 16'h2});
    vt.push_back('{1'b1, 1'b1, 16'h1, 3'd1, 1'b1, 1'b1, 16'h3});
    vt.push_back('{1'b1, 1'b1, 16'h2, 3'd1, 1'b1, 1'b1, 16'h4});
    vt.push_back('{1'b1, 1'b1, 16'h3, 3'd1, 1'b1, 1'b1, 16'h5});
    // reset mid-stream: everything back to zero
    vt.push_back('{1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0});
    // fill with ready low, stall in FULL, then drain and resume at 4
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1, 16'h0});
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd0, 1'b0, 1'b1, 16'h1});
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd1, 1'b1, 1'b1, 16'h2});
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd2, 1'b1, 1'b1, 16'h3});
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd3, 1'b1, 1'b0, 16'h3});
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd4, 1'b1, 1'b0, 16'h3});
    vt.push_back('{1'b1, 1'b0, 16'h0, 3'd4, 1'b1, 1'b0, 16'h3});
    vt.push_back('{1'b1, 1'b1, 16'h1, 3'd3, 1'b1, 1'b0, 16'h3});
    vt.push_back('{1'b1, 1'b1, 16'h2, 3'd2, 1'b1, 1'b1, 16'h4});
    vt.push_back('{1'b1, 1'b1, 16'h3, 3'd1, 1'b1, 1'b1, 16'h5});
    vt.push_back('{1'b1, 1'b1, 16'h4, 3'd1, 1'b1, 1'b1, 16'h6});
    vt.push_back('{1'b1, 1'b1, 16'h5, 3'd1, 1'b1, 1'b1, 16'h7});

    foreach (vt[i]) begin
      reset = vt[i].rst;
      bus.instr_ready = vt[i].rdy;
      step();
      chk($sformatf("v%0d.valid", i), 32'(bus.instr_valid), 32'(vt[i].exp_v));
      chk($sformatf("v%0d.count", i), 32'(bus.count), 32'(vt[i].exp_cnt));
      chk($sformatf("v%0d.mem_en", i), 32'(bus.mem_en), 32'(vt[i].exp_en));
      chk($sformatf("v%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vt[i].exp_addr));
      chk($sformatf("v%0d.pc", i), 32'(bus.instr_pc), 32'(vt[i].exp_pc));
      chk($sformatf("v%0d.instr", i), bus.instr,
          vt[i].exp_v ? 32'h1000_0000 + 32'(vt[i].exp_pc) : 32'h0);
    end

    // Redirect with 3 buffered and one word on the RAM bus.
    do_reset();
    repeat (5) step();
    chk("redir.pre_count", 32'(bus.count), 32'd3);
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0100; bus.instr_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    chk("redir.count", 32'(bus.count), 32'd0);
    chk("redir.valid", 32'(bus.instr_valid), 32'd0);
    chk("redir.mem_addr", 32'(bus.mem_addr), 32'h0100);
    chk("redir.hold_instr", bus.instr, 32'h1000_0000);
    step();
    chk("redir.drop", 32'(bus.count), 32'd0);
    chk("redir.mem_addr2", 32'(bus.mem_addr), 32'h0101);
    step();
    chk("redir.first_valid", 32'(bus.instr_valid), 32'd1);
    chk("redir.first_pc", 32'(bus.instr_pc), 32'h0100);
    chk("redir.first_instr", bus.instr, 32'h1000_0100);
    step();
    chk("redir.second_pc", 32'(bus.instr_pc), 32'h0101);

    // Halt with 2 buffered and one in flight: exactly three more words.
    do_reset();
    repeat (3) step();
    chk("halt.pre_count", 32'(bus.count), 32'd1);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    chk("halt.count", 32'(bus.count), 32'd2);
    chk("halt.mem_en", 32'(bus.mem_en), 32'd0);
    bus.instr_ready = 1'b1;
    delivered = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.instr_valid) begin
        chk($sformatf("halt.pc%0d", delivered), 32'(bus.instr_pc), 32'(delivered));
        delivered++;
      end
      step();
      chk($sformatf("halt.idle%0d", k), 32'(bus.mem_en), 32'd0);
    end
    chk("halt.delivered", 32'(delivered), 32'd3);
    // halt and redirect together: redirect wins
    bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 16'h0000;
    step();
    bus.halt = 1'b0; bus.redirect = 1'b0;
    chk("resume.mem_en", 32'(bus.mem_en), 32'd1);
    chk("resume.mem_addr", 32'(bus.mem_addr), 32'h0000);
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      step();
      if (bus.instr_valid) found = 1;
    end
    chk("resume.valid", 32'(found), 32'd1);
    chk("resume.pc", 32'(bus.instr_pc), 32'h0000);

    // Address wrap at the top of the space.
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect = 1'b0;
    chk("wrap.addr0", 32'(bus.mem_addr), 32'hFFFE);
    step();
    chk("wrap.addr1", 32'(bus.mem_addr), 32'hFFFF);
    step();
    chk("wrap.addr2", 32'(bus.mem_addr), 32'h0000);
    chk("wrap.pc0", 32'(bus.instr_pc), 32'hFFFE);
    step();
    chk("wrap.pc1", 32'(bus.instr_pc), 32'hFFFF);
    step();
    chk("wrap.pc2", 32'(bus.instr_pc), 32'h0000);
    chk("wrap.instr2", bus.instr, 32'h1000_0000);

    // Reset while three words are buffered.
    do_reset();
    repeat (5) step();
    chk("mrst.pre_count", 32'(bus.count), 32'd3);
    reset = 1'b0;
    step();
    chk("mrst.mem_en", 32'(bus.mem_en), 32'd0);
    chk("mrst.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("mrst.count", 32'(bus.count), 32'd0);
    chk("mrst.valid", 32'(bus.instr_valid), 32'd0);
    chk("mrst.instr", bus.instr, 32'd0);
    chk("mrst.pc", 32'(bus.instr_pc), 32'd0);
    reset = 1'b1;
    step();
    chk("mrst.restart_en", 32'(bus.mem_en), 32'd1);
    chk("mrst.restart_addr", 32'(bus.mem_addr), 32'd0);
    bus.instr_ready = 1'b1;
    step(); step();
    chk("mrst.restart_valid", 32'(bus.instr_valid), 32'd1);
    chk("mrst.restart_pc", 32'(bus.instr_pc), 32'd0);
    step();
    chk("mrst.restart_pc1", 32'(bus.instr_pc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Prefetch stage between the 32-bit instruction RAM and the controller. Streams sequential words from a synchronous RAM (1-cycle read latency) into a DEPTH-entry FIFO and presents them with a valid/ready handshake, each tagged with its fetch address. Supports a redirect (jump) that flushes all buffered and in-flight words, and a halt request that stops further fetching after an END opcode.

## Interface
- ADDR_W, 16, instruction address width
- DATA_W, 32, instruction word width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- mem_addr  out  ADDR_W  RAM read address
- mem_en  out  1  RAM read strobe; data for a strobed address is valid on mem_data the following cycle
- mem_data  in  DATA_W  RAM read data
- instr  out  DATA_W  FIFO head word
- instr_pc  out  ADDR_W  address of FIFO head word
- instr_valid  out  1  head entry present
- instr_ready  in  1  consumer accepts head this cycle
- redirect  in  1  one-cycle pulse: flush, restart at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- halt  in  1  one-cycle pulse: stop issuing fetches
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FSM states: FETCH, FULL, HALTED.
- FETCH: issue (mem_en=1, mem_addr=fetch_pc, fetch_pc+=1) when count + inflight < DEPTH; else go FULL.
- FULL: no issue; return to FETCH the cycle space frees (pop accepted).
- HALTED: entered on halt from any state; no issues; left only by redirect → FETCH.
- inflight: 1-bit flag, set on issue, cleared the next cycle when mem_data is pushed with its tag (the issued address).
- Pop: instr_valid && instr_ready; head advances, count decrements.
- Push and pop in the same cycle: count unchanged.
- Redirect (highest priority, any state): count=0, pointers reset, inflight data arriving next cycle is discarded, fetch_pc=redirect_pc, FSM=FETCH; pop in the same cycle is ignored; no issue in the redirect cycle.
- halt with redirect in the same cycle: redirect wins, FSM=FETCH.
- halt does not flush: buffered and in-flight words still deliver.
- fetch_pc wraps 0xFFFF→0x0000 modulo 2^ADDR_W; FIFO pointers wrap modulo DEPTH.
- instr/instr_pc hold last head value when instr_valid=0.

## Timing
- Reset values: mem_addr=0, mem_en=0, instr=0, instr_pc=0, instr_valid=0, count=0, fetch_pc=0, inflight=0, FSM=FETCH.
- First cycle after reset release (cycle 0): issue addr 0; cycle 1: push; cycle 2: instr_valid=1, instr_pc=0.
- Redirect at cycle N: first issue at N+1, first instr_valid at N+3.
- Sustained throughput: one word per cycle with instr_ready held high.
- Outputs are registered.

## Structure
- Shared package: ADDR_W/DATA_W defaults, FSM state encoding, OP_END = 8'hF0 constant (used by controller to drive halt).
- One sub-module: sync_fifo (DEPTH×(DATA_W+ADDR_W), show-ahead head, flush input).

## Test plan
- Reset release, instr_ready=1, RAM[i]=0x1000_0000+i → instr_pc 0,1,2,… on consecutive cycles from cycle 2, instr matches.
- instr_ready=0 from start → count reaches 4, mem_en stays 0 in FULL, no overflow; ready=1 → words 0..3 drain in order, fetch resumes at 4.
- Redirect to 0x0100 with 3 entries buffered and one in flight → count=0 next cycle, in-flight word dropped, next delivered instr_pc=0x0100.
- halt pulse with 2 buffered + 1 in flight → exactly 3 more words delivered, mem_en=0 thereafter; redirect to 0x0000 resumes.
- redirect_pc=0xFFFE → instr_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- reset=0 mid-stream with count=3 → next cycle all outputs at reset values, restart from address 0.
